// File: rtl/screen_ram_arbiter.sv
// Screen RAM access arbiter for an 80x25 text display.
// One RAM port is shared by three users. Display scan-out reads have absolute
// priority. The clear-screen sequencer comes next. Host accesses use a
// req/ack handshake and come last.
module screen_ram_arbiter #(
  parameter int          COLS     = 80,
  parameter int          ROWS     = 25,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_req,
  input  logic [11:0] disp_addr,
  output logic        disp_valid,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [11:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_wren,
  input  logic [7:0]  ram_q
);

  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [6:0]  cx_q, cx_d;
  logic [4:0]  cy_q, cy_d;
  logic        disp_valid_q;
  logic        ack_rd_q, ack_rd_d;
  logic        ack_oor_q, ack_oor_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        clr_pend_s;
  logic        host_in_range_s;

  // A clear request counts as pending in the same cycle it arrives, so an
  // idle arbiter enters CLEAR on the very next cycle.
  assign clr_pend_s      = pend_q | (clr_start & (state_q != CLEAR));
  assign host_in_range_s = (host_addr[6:0] <= COL_MAX) && (host_addr[11:7] <= ROW_MAX);

  assign disp_valid = disp_valid_q;
  assign clr_busy   = (state_q == CLEAR);

  // Next-state logic, the RAM port mux and the host response.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    ack_rd_d   = ack_rd_q;
    ack_oor_d  = ack_oor_q;
    rdata_d    = rdata_q;
    ram_addr   = disp_addr;
    ram_data   = 8'h00;
    ram_wren   = 1'b0;
    host_ack   = 1'b0;
    host_rdata = rdata_q;

    if (clr_start && (state_q != CLEAR)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      IDLE: begin
        if (clr_pend_s) begin
          // A pending clear wins over the host, even if the host asks in the same cycle.
          state_d = CLEAR;
          pend_d  = 1'b0;
          cx_d    = 7'd0;
          cy_d    = 5'd0;
        end else if (host_req && !disp_req) begin
          state_d   = ACK;
          ack_rd_d  = ~host_we;
          ack_oor_d = ~host_in_range_s;
          ram_addr  = host_addr;
          ram_data  = host_wdata;
          ram_wren  = host_we & host_in_range_s;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        host_ack = 1'b1;
        // ram_q holds the data for the address presented in the grant cycle.
        if (ack_rd_q) begin
          host_rdata = ack_oor_q ? 8'h00 : ram_q;
          rdata_d    = host_rdata;
        end else begin
          host_rdata = rdata_q;
        end
        if (clr_pend_s) begin
          state_d = CLEAR;
          pend_d  = 1'b0;
          cx_d    = 7'd0;
          cy_d    = 5'd0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (!disp_req) begin
          ram_addr = {cy_q, cx_q};
          ram_data = CLR_CHAR;
          ram_wren = 1'b1;
          if (cx_q == COL_MAX) begin
            cx_d = 7'd0;
            if (cy_q == ROW_MAX) begin
              cy_d    = 5'd0;
              state_d = IDLE;
            end else begin
              cy_d = cy_q + 5'd1;
            end
          end else begin
            cx_d = cx_q + 7'd1;
          end
        end else begin
          state_d = CLEAR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, the read-data hold register and the display valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      cx_q         <= 7'd0;
      cy_q         <= 5'd0;
      disp_valid_q <= 1'b0;
      ack_rd_q     <= 1'b0;
      ack_oor_q    <= 1'b0;
      rdata_q      <= 8'h00;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      disp_valid_q <= disp_req;
      ack_rd_q     <= ack_rd_d;
      ack_oor_q    <= ack_oor_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_screen_ram_arbiter.sv
// Scoreboard testbench for screen_ram_arbiter with a behavioural screen RAM.
module tb_screen_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_req = 1'b0;
  logic [11:0] disp_addr = 12'h000;
  logic        disp_valid;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [11:0] host_addr = 12'h000;
  logic [7:0]  host_wdata = 8'h00;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic [7:0]  ram_q = 8'h00;

  logic [7:0]  mem [4096];
  logic [8:0]  exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          wren_cnt = 0;
  int          clr_wr = 0;
  logic [6:0]  clr_cx = 7'd0;
  logic [4:0]  clr_cy = 5'd0;
  logic        prev_disp = 1'b0;

  screen_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Screen RAM model: registered address/data, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on host_ack; also checks display priority,
  // disp_valid timing and the clear write sequence.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_disp = 1'b0;
    end else begin
      chk("disp_valid", {31'd0, disp_valid}, {31'd0, prev_disp});
      prev_disp = disp_req;
      if (disp_req) begin
        chk("disp_wren", {31'd0, ram_wren}, 32'd0);
        chk("disp_addr", {20'd0, ram_addr}, {20'd0, disp_addr});
      end
      if (clr_start && !clr_busy) begin
        clr_cx = 7'd0;
        clr_cy = 5'd0;
        clr_wr = 0;
      end
      if (ram_wren) wren_cnt++;
      if (ram_wren && clr_busy) begin
        chk("clr_addr", {20'd0, ram_addr}, {20'd0, clr_cy, clr_cx});
        chk("clr_data", {24'd0, ram_data}, 32'h20);
        clr_wr++;
        if (clr_cx == 7'd79) begin
          clr_cx = 7'd0;
          clr_cy = clr_cy + 5'd1;
        end else begin
          clr_cx = clr_cx + 7'd1;
        end
      end
      if (host_ack) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", 32'd1, 32'd0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if (e[8]) chk("host_rdata", {24'd0, host_rdata}, {24'd0, e[7:0]});
        end
      end
    end
  end

  // One host access; returns the number of negedges until ack and clr_busy at ack.
  task automatic host_access(input logic we, input logic [11:0] a, input logic [7:0] d,
                             input logic [7:0] exp, output int lat, output logic busy_at_ack);
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    exp_q.push_back({~we, exp});
    lat = 0;
    busy_at_ack = 1'b1;
    while (lat < 6000) begin
      @(negedge clk);
      lat++;
      if (host_ack) break;
    end
    if (!host_ack) chk("host_timeout", 32'd0, 32'd1);
    busy_at_ack = clr_busy;
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  int   lat, w0, cnt;
  logic bsy;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'hEE;
    // Reset state
    #12;
    chk("rst_disp_valid", {31'd0, disp_valid}, 32'd0);
    chk("rst_host_ack",   {31'd0, host_ack},   32'd0);
    chk("rst_clr_busy",   {31'd0, clr_busy},   32'd0);
    chk("rst_ram_wren",   {31'd0, ram_wren},   32'd0);
    chk("rst_host_rdata", {24'd0, host_rdata}, 32'd0);
    @(negedge clk); #1; rst_n = 1'b1;

    // Host write then read back of {3,10}
    w0 = wren_cnt;
    host_access(1'b1, {5'd3, 7'd10}, 8'h41, 8'h00, lat, bsy);
    chk("wr_latency", lat, 32'd2);
    chk("wr_wren_cycles", wren_cnt - w0, 32'd1);
    host_access(1'b0, {5'd3, 7'd10}, 8'h00, 8'h41, lat, bsy);
    chk("rd_latency", lat, 32'd2);
    repeat (3) @(negedge clk);
    chk("rd_hold", {24'd0, host_rdata}, 32'h41);

    // Display holds the port for 5 cycles while the host waits
    w0 = wren_cnt;
    @(posedge clk); #1;
    disp_req = 1'b1; disp_addr = 12'h123;
    host_req = 1'b1; host_we = 1'b0; host_addr = {5'd3, 7'd10};
    exp_q.push_back({1'b1, 8'h41});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("disp_block_ack", {31'd0, host_ack}, 32'd0);
      @(posedge clk); #1;
      if (i < 4) disp_addr = disp_addr + 12'd1;
      else disp_req = 1'b0;
    end
    @(negedge clk);
    chk("grant_cycle_ack", {31'd0, host_ack}, 32'd0);
    @(negedge clk);
    chk("ack_after_disp", {31'd0, host_ack}, 32'd1);
    @(posedge clk); #1; host_req = 1'b0;
    chk("disp_block_wren", wren_cnt - w0, 32'd0);

    // Out-of-range write and read
    w0 = wren_cnt;
    host_access(1'b1, {5'd25, 7'd0}, 8'h55, 8'h00, lat, bsy);
    chk("oor_wr_latency", lat, 32'd2);
    host_access(1'b0, {5'd0, 7'd80}, 8'h00, 8'h00, lat, bsy);
    chk("oor_rd_latency", lat, 32'd2);
    chk("oor_wren", wren_cnt - w0, 32'd0);
    chk("oor_rd_hold", {24'd0, host_rdata}, 32'd0);
    chk("oor_mem_untouched", {24'd0, mem[{5'd25, 7'd0}]}, 32'hEE);

    // Full clear with the display idle
    @(posedge clk); #1; clr_start = 1'b1;
    @(negedge clk);
    chk("clr_busy_start_cycle", {31'd0, clr_busy}, 32'd0);
    @(posedge clk); #1; clr_start = 1'b0;
    cnt = 0;
    while (cnt < 5000) begin
      @(negedge clk);
      if (!clr_busy) break;
      cnt++;
    end
    #1;
    chk("clr_busy_cycles", cnt, 32'd2000);
    chk("clr_write_count", clr_wr, 32'd2000);
    chk("clr_col80_untouched", {24'd0, mem[{5'd0, 7'd80}]}, 32'hEE);
    host_access(1'b0, {5'd0, 7'd0},   8'h00, 8'h20, lat, bsy);
    host_access(1'b0, {5'd24, 7'd79}, 8'h00, 8'h20, lat, bsy);
    host_access(1'b0, {5'd3, 7'd10},  8'h00, 8'h20, lat, bsy);

    // Clear with the display toggling every cycle and a host request mid-clear
    @(posedge clk); #1; clr_start = 1'b1;
    fork
      begin
        for (int i = 0; i < 4000; i++) begin
          @(posedge clk); #1;
          clr_start = 1'b0;
          disp_req = ~disp_req;
          disp_addr = disp_addr + 12'd7;
        end
      end
      begin
        @(negedge clk);
        cnt = 0;
        while (cnt < 9000) begin
          @(negedge clk);
          if (!clr_busy) break;
          cnt++;
        end
        chk("clr_toggle_cycles", cnt, 32'd4000);
      end
      begin
        repeat (100) @(posedge clk);
        host_access(1'b0, {5'd1, 7'd1}, 8'h00, 8'h20, lat, bsy);
        chk("host_ack_after_clear", {31'd0, bsy}, 32'd0);
        chk("host_wait_long", {31'd0, (lat > 3800)}, 32'd1);
      end
    join
    chk("clr_toggle_writes", clr_wr, 32'd2000);

    // Reset in the middle of a clear
    for (int i = 0; i < 4096; i++) mem[i] = 8'hEE;
    @(posedge clk); #1; clr_start = 1'b1;
    @(posedge clk); #1; clr_start = 1'b0;
    cnt = 0;
    while (cnt < 3000) begin
      @(negedge clk); #1;
      if (clr_wr >= 1000) break;
      cnt++;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    chk("mid_rst_wren",     {31'd0, ram_wren}, 32'd0);
    chk("mid_rst_ack",      {31'd0, host_ack}, 32'd0);
    chk("mid_rst_valid",    {31'd0, disp_valid}, 32'd0);
    chk("mid_rst_rdata",    {24'd0, host_rdata}, 32'd0);
    chk("mid_rst_ram_data", {24'd0, ram_data}, 32'd0);
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b1;
    host_access(1'b0, {5'd0, 7'd0},   8'h00, 8'h20, lat, bsy);
    chk("post_rst_latency", lat, 32'd2);
    host_access(1'b0, {5'd12, 7'd37}, 8'h00, 8'h20, lat, bsy);
    host_access(1'b0, {5'd12, 7'd45}, 8'h00, 8'hEE, lat, bsy);
    chk("post_rst_not_busy", {31'd0, clr_busy}, 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
